// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports with write-through bypass, a per-register pending scoreboard and
// a hardware clear sequence that zeroes the array after reset.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | clear sequence running, one register zeroed per cycle
// ST_READY | normal operation: writes, reads, issue tracking
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_init_busy,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_pending,
    input  logic                     i_wr0_en,
    input  logic [ADDR_W-1:0]        i_wr0_addr,
    input  logic [DATA_W-1:0]        i_wr0_data,
    input  logic                     i_wr1_en,
    input  logic [ADDR_W-1:0]        i_wr1_addr,
    input  logic [DATA_W-1:0]        i_wr1_data,
    input  logic                     i_issue_en,
    input  logic [ADDR_W-1:0]        i_issue_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_init_busy;
    logic [DEPTH-1:0]    r_pending;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_ready;
    logic                w_wr0_store;
    logic                w_wr1_store;
    logic                w_issue_set;
    logic [DEPTH-1:0]    w_pend_next;

    assign w_ready     = (r_state == ST_READY);
    assign o_init_busy = r_init_busy;

    // Register 0 is hardwired when ZERO_REG is set, so its writes and issues vanish.
    assign w_wr0_store = w_ready && i_wr0_en && !(ZERO_REG && (i_wr0_addr == '0));
    assign w_wr1_store = w_ready && i_wr1_en && !(ZERO_REG && (i_wr1_addr == '0));
    assign w_issue_set = i_issue_en && !(ZERO_REG && (i_issue_addr == '0));

    // Next pending vector: writes retire producers, a new issue sets last so it wins.
    always_comb begin
        w_pend_next = r_pending;
        if (i_wr0_en) begin
            w_pend_next[i_wr0_addr] = 1'b0;
        end
        if (i_wr1_en) begin
            w_pend_next[i_wr1_addr] = 1'b0;
        end
        if (w_issue_set) begin
            w_pend_next[i_issue_addr] = 1'b1;
        end
    end

    // Control FSM: clear counter, busy flag and pending scoreboard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_pending   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_IDX) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_pending <= w_pend_next;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: zeroed by the clear sequence, left untouched while in reset;
    // port 1 is written last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= '0;
            end else begin
                if (w_wr0_store) begin
                    r_mem[i_wr0_addr] <= i_wr0_data;
                end
                if (w_wr1_store) begin
                    r_mem[i_wr1_addr] <= i_wr1_data;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_wr0_hit;
        logic              w_wr1_hit;

        assign w_addr    = i_rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_wr0_hit = i_wr0_en && (i_wr0_addr == w_addr);
        assign w_wr1_hit = i_wr1_en && (i_wr1_addr == w_addr);

        // Read mux with same-cycle bypass, mirroring the array's write priority.
        always_comb begin
            w_data = '0;
            if (!w_ready) begin
                w_data = '0;
            end else if (ZERO_REG && (w_addr == '0)) begin
                w_data = '0;
            end else if (w_wr1_hit) begin
                w_data = i_wr1_data;
            end else if (w_wr0_hit) begin
                w_data = i_wr0_data;
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign o_rd_data[gi*DATA_W +: DATA_W] = w_data;
        // A writeback arriving this cycle already satisfies the consumer.
        assign o_rd_pending[gi] = w_ready && r_pending[w_addr] && !w_wr0_hit && !w_wr1_hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances in lockstep (32x32 with 4 read ports and
// hardwired r0, and 8x64 with 2 read ports and writable r0), driven by the same
// stimulus and checked against a behavioural model through a scoreboard queue.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr0_en, wr1_en, issue_en;
    logic [4:0]  wr0_addr, wr1_addr, issue_addr;
    logic [63:0] wr0_data, wr1_data;
    logic [4:0]  ra [4];

    logic         busy_a, busy_b;
    logic [19:0]  rd_addr_a;
    logic [5:0]   rd_addr_b;
    logic [127:0] rd_data_a, rd_data_b;
    logic [3:0]   rd_pend_a;
    logic [1:0]   rd_pend_b;

    assign rd_addr_a = {ra[3], ra[2], ra[1], ra[0]};
    assign rd_addr_b = {ra[1][2:0], ra[0][2:0]};

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .o_init_busy(busy_a),
        .i_rd_addr(rd_addr_a), .o_rd_data(rd_data_a), .o_rd_pending(rd_pend_a),
        .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data[31:0]),
        .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data[31:0]),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .o_init_busy(busy_b),
        .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b), .o_rd_pending(rd_pend_b),
        .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr[2:0]), .i_wr0_data(wr0_data),
        .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr[2:0]), .i_wr1_data(wr1_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr[2:0])
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;

    function automatic void chk(string name, int id, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, id, act, exp);
        end
    endfunction

    // ---------------- behavioural model (config 0 = A, 1 = B) ----------------
    logic [63:0] m_mem  [2][32];
    bit          m_pend [2][32];
    int          m_left [2];     // clear cycles still to run; 0 means ready

    function automatic int dep(int c);
        return (c == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] msk(int c);
        return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] m_read(int c, logic [4:0] addr);
        int a = int'(addr) % dep(c);
        if (m_left[c] != 0) return 64'h0;
        if (c == 0 && a == 0) return 64'h0;
        if (wr1_en && (int'(wr1_addr) % dep(c)) == a) return wr1_data & msk(c);
        if (wr0_en && (int'(wr0_addr) % dep(c)) == a) return wr0_data & msk(c);
        return m_mem[c][a];
    endfunction

    function automatic logic m_pend_rd(int c, logic [4:0] addr);
        int a = int'(addr) % dep(c);
        if (m_left[c] != 0) return 1'b0;
        if (wr1_en && (int'(wr1_addr) % dep(c)) == a) return 1'b0;
        if (wr0_en && (int'(wr0_addr) % dep(c)) == a) return 1'b0;
        return m_pend[c][a];
    endfunction

    function automatic void m_edge();
        for (int c = 0; c < 2; c++) begin
            int d  = dep(c);
            int a0 = int'(wr0_addr) % d;
            int a1 = int'(wr1_addr) % d;
            int ai = int'(issue_addr) % d;
            if (rst) begin
                m_left[c] = d;
                for (int k = 0; k < 32; k++) m_pend[c][k] = 1'b0;
            end else if (m_left[c] != 0) begin
                m_mem[c][d - m_left[c]] = 64'h0;
                m_left[c]--;
            end else begin
                if (wr0_en && !(c == 0 && a0 == 0)) m_mem[c][a0] = wr0_data & msk(c);
                if (wr1_en && !(c == 0 && a1 == 0)) m_mem[c][a1] = wr1_data & msk(c);
                if (wr0_en) m_pend[c][a0] = 1'b0;
                if (wr1_en) m_pend[c][a1] = 1'b0;
                if (issue_en && !(c == 0 && ai == 0)) m_pend[c][ai] = 1'b1;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int           id;
        logic         busy_a;
        logic [127:0] data_a;
        logic [3:0]   pend_a;
        logic         busy_b;
        logic [127:0] data_b;
        logic [1:0]   pend_b;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: compare the DUT outputs of each cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("busy_a", mon_e.id, 128'(busy_a), 128'(mon_e.busy_a));
            chk("data_a", mon_e.id, rd_data_a, mon_e.data_a);
            chk("pend_a", mon_e.id, 128'(rd_pend_a), 128'(mon_e.pend_a));
            chk("busy_b", mon_e.id, 128'(busy_b), 128'(mon_e.busy_b));
            chk("data_b", mon_e.id, rd_data_b, mon_e.data_b);
            chk("pend_b", mon_e.id, 128'(rd_pend_b), 128'(mon_e.pend_b));
        end
    end

    // One clock: queue the expected outputs for the current inputs, then advance.
    task automatic step();
        exp_t        e;
        logic [63:0] v;
        e.id     = n_steps;
        e.busy_a = (m_left[0] != 0);
        e.busy_b = (m_left[1] != 0);
        for (int i = 0; i < 4; i++) begin
            v = m_read(0, ra[i]);
            e.data_a[i*32 +: 32] = v[31:0];
            e.pend_a[i] = m_pend_rd(0, ra[i]);
        end
        for (int i = 0; i < 2; i++) begin
            e.data_b[i*64 +: 64] = m_read(1, ra[i]);
            e.pend_b[i] = m_pend_rd(1, ra[i]);
        end
        exp_q.push_back(e);
        @(posedge clk);
        m_edge();
        #1;
        n_steps++;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic set_ra(logic [4:0] a);
        for (int i = 0; i < 4; i++) ra[i] = a;
    endtask

    // Run the clear sequence to completion, returning cycles spent busy per instance.
    task automatic wait_init(output int na, output int nb);
        na = 0;
        nb = 0;
        while (busy_a === 1'b1 && na < 100) begin
            if (busy_b === 1'b1) nb++;
            step();
            na++;
        end
    endtask

    int na, nb;

    initial begin
        rst = 1'b1;
        idle();
        set_ra(5'd0);
        m_left[0] = 32;
        m_left[1] = 8;
        @(posedge clk);
        m_edge();
        #1;
        step();
        step();

        // Reset release, clear timing, and a write during INIT that must be ignored.
        rst = 1'b0;
        na  = 0;
        nb  = 0;
        while (busy_a === 1'b1 && na < 100) begin
            if (busy_b === 1'b1) nb++;
            if (na == 3) begin
                wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'hDEAD;
            end else begin
                idle();
            end
            step();
            na++;
        end
        idle();
        chk("init_cycles_a", 0, 128'(na), 128'(32));
        chk("init_cycles_b", 0, 128'(nb), 128'(8));
        for (int a = 0; a < 32; a++) begin
            for (int i = 0; i < 4; i++) ra[i] = 5'((a + i) % 32);
            step();
        end

        // Dual write to r7: port 1 wins, both bypassed and stored.
        set_ra(5'd7);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h1111_1111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h2222_2222;
        step();
        idle();
        step();

        // Bypass on every port, then r0 stays zero while targeted by wr1.
        set_ra(5'd3);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'hA5A5_A5A5;
        step();
        idle();
        step();
        set_ra(5'd0);
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 64'hFFFF_FFFF;
        step();
        idle();
        step();

        // Scoreboard on r9: issue, clear by write, and issue+write where set wins.
        set_ra(5'd9);
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        idle();
        step();
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h99;
        step();
        idle();
        step();
        issue_en = 1'b1; issue_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h1234;
        step();
        idle();
        step();

        // r0 is writable in the 8x64 instance.
        set_ra(5'd0);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'h0123_4567_89AB_CDEF;
        step();
        idle();
        step();

        // Reset mid-INIT at counter 10 restarts the full clear.
        issue_en = 1'b1; issue_addr = 5'd12;
        step();
        idle();
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init(na, nb);
        chk("restart_cycles_a", 1, 128'(na), 128'(32));
        chk("restart_cycles_b", 1, 128'(nb), 128'(8));
        set_ra(5'd12);
        step();

        // Randomised traffic with address collisions and rare resets.
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            wr0_en     = $urandom_range(0, 1) == 1;
            wr1_en     = $urandom_range(0, 2) == 0;
            issue_en   = $urandom_range(0, 1) == 1;
            wr0_addr   = 5'($urandom_range(0, 31));
            wr1_addr   = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
            issue_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
            wr0_data   = {$urandom, $urandom};
            wr1_data   = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: ra[i] = wr0_addr;
                    1: ra[i] = wr1_addr;
                    2: ra[i] = issue_addr;
                    default: ra[i] = 5'($urandom_range(0, 31));
                endcase
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", n_steps, 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port successor to the single-write, two-read register file used by the pipeline.
- Generalised data width, depth and read-port count.
- Two write ports (e.g. ALU and load writeback) with fixed priority and write-through bypass on every read port.
- Per-register pending scoreboard so decode can detect outstanding producers.
- Hardware clear sequence after reset, replacing file-based initialisation.
Sits between decode (reads, issue) and writeback (writes).

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/issue

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
init_busy  out  1  registered; high while clear sequence runs
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_pending  out  NUM_RD  per-port: addressed register awaits writeback
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (priority over port 0)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
issue_en  in  1  mark issue_addr pending (new producer issued)
issue_addr  in  ADDR_W  destination of issued instruction

Behaviour:
- FSM states: INIT, READY.
- While rst=1 at a clock edge:
  - state <= INIT, clear counter <= 0, all pending bits <= 0, init_busy <= 1.
  - Array contents are not touched.
- INIT, rst=0: each cycle writes 0 to reg[counter], counter increments.
  - On the cycle writing DEPTH-1: state <= READY, init_busy <= 0.
  - First cycle with init_busy=0 is exactly DEPTH cycles after rst deasserts (32 for defaults).
- Reset asserted mid-INIT restarts the sequence from counter 0.
- During INIT:
  - wr0/wr1/issue are ignored: no array or pending change.
  - rd_data = 0 and rd_pending = 0 on all ports.
- READY writes, on the edge:
  - wrN_en=1 writes wrN_data to reg[wrN_addr].
  - Both enabled to the same address: wr1 value is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- READY reads, each port independent, combinational, same priority as the array:
  - ZERO_REG=1 and addr=0 -> 0.
  - else wr1_en && wr1_addr=addr -> wr1_data.
  - else wr0_en && wr0_addr=addr -> wr0_data.
  - else reg[addr].
- Pending scoreboard, READY only:
  - A write (either port) to address a clears pending[a] at the edge.
  - issue_en sets pending[issue_addr] at the edge.
  - Issue and write to the same address in the same cycle: set wins, leaving the bit at 1.
  - Address 0 is never set when ZERO_REG=1.
- rd_pending[i] = pending[addr] AND NOT (a write to addr is enabled this cycle). Same-cycle issue_en does not affect the current cycle's rd_pending.
- No arithmetic wrap concerns except the clear counter, which is ADDR_W+1 bits so it can reach DEPTH.
- No combinational path from rd_addr to any registered state.

Test Plan:
- Reset/clear: hold rst 3 cycles, release. Required:
  - init_busy=1 for exactly 32 cycles after release, then 0.
  - All 32 registers read 0.
  - wr0 to r5 with 0xDEAD during INIT leaves r5=0.
- Dual write priority: READY, wr0 (r7, 0x11111111) and wr1 (r7, 0x22222222) same cycle. Required:
  - Read port 0 on r7 returns 0x22222222 both combinationally that cycle and from the array the next cycle.
- Bypass on all ports, NUM_RD=4:
  - wr0 (r3, 0xA5A5A5A5) with all rd_addr=3 -> every rd_data lane 0xA5A5A5A5 in the same cycle.
  - r0 reads 0 while wr1 targets r0 with 0xFFFFFFFF.
- Scoreboard:
  - issue r9 -> next cycle rd_pending=1 for r9.
  - wr0 r9 that cycle -> rd_pending=0 same cycle; bit cleared after the edge.
  - issue r9 together with wr1 r9 -> bit remains 1.
- Reset mid-INIT: assert rst at counter=10. Required:
  - Pending cleared, init_busy stays 1.
  - A full 32 further cycles elapse after release before READY.
- Parameter sweep: DATA_W=64, ADDR_W=3, ZERO_REG=0. Required:
  - init_busy low after 8 cycles.
  - Write 0x0123456789ABCDEF to r0 reads back, proving r0 is writable.
